peak_average: RTL

PEAK_AVERAGE -- requirements
Module: peak_average

---
 rtl/peak_average.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/peak_average.sv
// peak_average: averages 2^AVG_SHIFT framed peak batches per peak index and emits one framed packet per average.
// Define PEAK_AVERAGE_ERRCNT_EN to enable the saturating dropped-batch counter on error_count.
module peak_average #(
  parameter int NPEAKS    = 4,
  parameter int AVG_SHIFT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic        sink_valid,
  input  logic [31:0] sink_freq,
  input  logic [31:0] sink_mag,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic        source_valid,
  output logic [31:0] source_freq,
  output logic [31:0] source_mag,
  output logic [15:0] error_count
);
  localparam int PW = NPEAKS > 1 ? $clog2(NPEAKS) : 1;
  localparam int AW = 32 + AVG_SHIFT;
  localparam int BW = AVG_SHIFT + 1;
  typedef enum logic [1:0] {COLLECT, COMMIT, OUTPUT} state_t;
  state_t state_q, state_d;
  logic open_q, open_d;
  logic [PW-1:0] beat_pos_q, beat_pos_d, out_pos_q, out_pos_d, pos, nxt;
  logic [BW-1:0] batch_cnt_q, batch_cnt_d;
  logic [31:0] buf_freq_q [NPEAKS], buf_freq_d [NPEAKS];
  logic [31:0] buf_mag_q [NPEAKS], buf_mag_d [NPEAKS];
  logic signed [AW-1:0] acc_freq_q [NPEAKS], acc_freq_d [NPEAKS];
  logic signed [AW-1:0] acc_mag_q [NPEAKS], acc_mag_d [NPEAKS];
  logic signed [AW-1:0] shf_f, shf_m;
  logic src_valid_q, src_valid_d, src_sop_q, src_sop_d, src_eop_q, src_eop_d;
  logic [31:0] src_freq_q, src_freq_d, src_mag_q, src_mag_d;
  logic collect, accept, last, good, tx, out_last;
  assign collect  = state_q == COLLECT;
  assign pos      = sink_sop ? '0 : beat_pos_q;
  assign accept   = collect && sink_valid && (sink_sop || open_q);
  assign last     = pos == PW'(NPEAKS - 1);
  assign good     = accept && sink_eop && last;
  assign tx       = src_valid_q && source_ready;
  assign out_last = out_pos_q == PW'(NPEAKS - 1);
  always_ff @(posedge clk) state_q <= reset ? COLLECT : state_d;
  always_comb begin
    state_d = state_q;
    if (good)
      state_d = COMMIT;
    else if (state_q == COMMIT)
      state_d = batch_cnt_d == BW'(2 ** AVG_SHIFT) ? OUTPUT : COLLECT;
    else if (state_q == OUTPUT && tx && out_last)
      state_d = COLLECT;
  end
  always_comb begin
    open_d      = open_q;
    beat_pos_d  = beat_pos_q;
    batch_cnt_d = batch_cnt_q;
    buf_freq_d  = buf_freq_q;
    buf_mag_d   = buf_mag_q;
    acc_freq_d  = acc_freq_q;
    acc_mag_d   = acc_mag_q;
    out_pos_d   = out_pos_q;
    src_valid_d = src_valid_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    src_freq_d  = src_freq_q;
    src_mag_d   = src_mag_q;
    nxt         = src_valid_q ? out_pos_q + 1'b1 : '0;
    shf_f       = acc_freq_q[nxt] >>> AVG_SHIFT;
    shf_m       = acc_mag_q[nxt] >>> AVG_SHIFT;
    if (accept) begin
      buf_freq_d[pos] = sink_freq;
      buf_mag_d[pos]  = sink_mag;
      open_d          = !(sink_eop || last);
      beat_pos_d      = (sink_eop || last) ? '0 : pos + 1'b1;
    end
    if (state_q == COMMIT) begin
      for (int i = 0; i < NPEAKS; i++) begin
        acc_freq_d[i] = acc_freq_q[i] + AW'($signed(buf_freq_q[i]));
        acc_mag_d[i]  = acc_mag_q[i] + AW'($signed(buf_mag_q[i]));
      end
      batch_cnt_d = batch_cnt_q + 1'b1;
    end
    // first OUTPUT cycle loads beat 0; later beats advance only on a transfer
    if (state_q == OUTPUT && (!src_valid_q || tx)) begin
      if (src_valid_q && out_last) begin
        src_valid_d = 1'b0;
        src_sop_d   = 1'b0;
        src_eop_d   = 1'b0;
        batch_cnt_d = '0;
        acc_freq_d  = '{default: '0};
        acc_mag_d   = '{default: '0};
      end else begin
        src_valid_d = 1'b1;
        src_sop_d   = nxt == '0;
        src_eop_d   = nxt == PW'(NPEAKS - 1);
        src_freq_d  = shf_f[31:0];
        src_mag_d   = shf_m[31:0];
        out_pos_d   = nxt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      open_q      <= 1'b0;
      beat_pos_q  <= '0;
      batch_cnt_q <= '0;
      acc_freq_q  <= '{default: '0};
      acc_mag_q   <= '{default: '0};
      out_pos_q   <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_freq_q  <= '0;
      src_mag_q   <= '0;
    end else begin
      open_q      <= open_d;
      beat_pos_q  <= beat_pos_d;
      batch_cnt_q <= batch_cnt_d;
      acc_freq_q  <= acc_freq_d;
      acc_mag_q   <= acc_mag_d;
      out_pos_q   <= out_pos_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      src_freq_q  <= src_freq_d;
      src_mag_q   <= src_mag_d;
    end
  end
  always_ff @(posedge clk) begin
    buf_freq_q <= buf_freq_d;
    buf_mag_q  <= buf_mag_d;
  end
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign source_freq  = src_freq_q;
  assign source_mag   = src_mag_q;
`ifdef PEAK_AVERAGE_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;
  logic e_part, e_other;
  // a sop on an open frame can also be a malformed one-beat frame: two errors in one edge
  assign e_part  = accept && sink_sop && open_q;
  assign e_other = (accept && (sink_eop != last)) || (collect && sink_valid && !sink_sop && !open_q) ||
                   (!collect && sink_valid && sink_sop);
  always_comb begin
    err_sum = {1'b0, err_q} + 17'(e_part) + 17'(e_other);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
  always_ff @(posedge clk) err_q <= reset ? '0 : err_d;
  assign error_count = err_q;
`else
  assign error_count = '0;
`endif
endmodule
